// File: rtl/trojan9_chk_pkg.sv
// Shared types and constants for the trojan9 result checker: FSM states, mode encodings,
// product indices and the term-select helper that mirrors the arithmetic core.
package trojan9_chk_pkg;

   typedef enum logic [1:0] {IDLE, MUL, CMP, RESP} state_t;

   localparam int MUL_ITERS = 9;

   localparam logic [1:0] MODE_M1 = 2'd0;
   localparam logic [1:0] MODE_M2 = 2'd1;
   localparam logic [1:0] MODE_M3 = 2'd2;
   localparam logic [1:0] MODE_M4 = 2'd3;

   localparam logic [1:0] P1 = 2'd0;
   localparam logic [1:0] P2 = 2'd1;
   localparam logic [1:0] P3 = 2'd2;
   localparam logic [1:0] P4 = 2'd3;

   // All terms wrap mod 2^16, exactly like the core's datapath.
   function automatic logic [15:0] select_term(input logic [1:0] mode,
                                               input logic [3:0][15:0] prod);
      logic [15:0] m1, m2, m3, m4;
      m1 = prod[P1];
      m2 = prod[P2] + prod[P3];
      m3 = prod[P4];
      m4 = (m1 + m2) ^ (m3 >> 2);
      case (mode)
         MODE_M1: select_term = m1;
         MODE_M2: select_term = m2;
         MODE_M3: select_term = m3;
         default: select_term = m4;
      endcase
   endfunction

endpackage

// File: rtl/trojan9_shift_add_mul.sv
// Serial shift-add multiplier: 16-bit multiplicand x 9-bit multiplier, one multiplier bit
// per cycle LSB first; the product (mod 2^16) is valid while done pulses on the 9th cycle.
module trojan9_shift_add_mul
   import trojan9_chk_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] mcand,
   input  logic [8:0]  mplier,
   output logic        done,
   output logic [15:0] product
);

   logic        busy_q, busy_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] mcand_q, mcand_d;
   logic [8:0]  mplier_q, mplier_d;

   logic [15:0] cur_acc, cur_mcand, sum;
   logic [8:0]  cur_mplier;
   logic [3:0]  cur_cnt;
   logic        active;

   // The start cycle already consumes bit 0 straight from the ports, so nine cycles suffice.
   always_comb begin
      cur_mcand  = start ? mcand  : mcand_q;
      cur_mplier = start ? mplier : mplier_q;
      cur_acc    = start ? 16'h0000 : acc_q;
      cur_cnt    = start ? 4'd0 : cnt_q;
      active     = start | busy_q;
      sum        = cur_acc + (cur_mplier[0] ? cur_mcand : 16'h0000);

      done       = active && (cur_cnt == 4'(MUL_ITERS - 1));
      product    = sum;

      busy_d     = active && (cur_cnt != 4'(MUL_ITERS - 1));
      cnt_d      = active ? cur_cnt + 4'd1 : cnt_q;
      acc_d      = active ? sum : acc_q;
      mcand_d    = active ? cur_mcand << 1 : mcand_q;
      mplier_d   = active ? cur_mplier >> 1 : mplier_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= 1'b0;
         cnt_q    <= 4'd0;
         acc_q    <= 16'h0000;
         mcand_q  <= 16'h0000;
         mplier_q <= 9'h000;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule

// File: rtl/trojan9_result_checker.sv
// Recomputes the arithmetic core's result serially from a captured operand tuple, compares it
// with the observed value and reports through a ready/valid response with saturating counters.
module trojan9_result_checker
   import trojan9_chk_pkg::*;
#(
   parameter logic [15:0] COMPUTATION_BIAS = 16'h1234,
   parameter int          CNT_W            = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   input  logic [7:0]       c,
   input  logic [7:0]       d,
   input  logic [7:0]       e,
   input  logic [1:0]       mode,
   input  logic [15:0]      y_obs,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_mismatch,
   output logic [15:0]      resp_expected,
   output logic [CNT_W-1:0] txn_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t             state_q, state_d;
   logic [7:0]         a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, e_q, e_d;
   logic [1:0]         mode_q, mode_d;
   logic [15:0]        y_obs_q, y_obs_d;
   logic [3:0][15:0]   prod_q, prod_d;
   logic [1:0]         prod_idx_q, prod_idx_d;
   logic               mul_start_q, mul_start_d;
   logic               resp_mismatch_q, resp_mismatch_d;
   logic [15:0]        resp_expected_q, resp_expected_d;
   logic [CNT_W-1:0]   txn_q, txn_d, err_q, err_d;

   logic [15:0]        mul_mcand, mul_product, expected_calc;
   logic [8:0]         mul_mplier;
   logic               mul_done;

   trojan9_shift_add_mul u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start_q),
      .mcand   (mul_mcand),
      .mplier  (mul_mplier),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      mul_mcand  = 16'h0000;
      mul_mplier = 9'h000;
      case (prod_idx_q)
         P1: begin
            mul_mcand  = 16'(a_q) + 16'(b_q);
            mul_mplier = {1'b0, c_q} + {1'b0, d_q};
         end
         P2: begin
            mul_mcand  = 16'(a_q);
            mul_mplier = {1'b0, c_q};
         end
         P3: begin
            mul_mcand  = 16'(b_q);
            mul_mplier = {1'b0, d_q};
         end
         default: begin
            mul_mcand  = 16'({1'b0, a_q ^ b_q} + {1'b0, d_q});
            mul_mplier = {5'b00000, e_q[3:0]};
         end
      endcase
   end

   assign expected_calc = select_term(mode_q, prod_q) + COMPUTATION_BIAS;

   always_comb begin
      state_d         = state_q;
      a_d             = a_q;
      b_d             = b_q;
      c_d             = c_q;
      d_d             = d_q;
      e_d             = e_q;
      mode_d          = mode_q;
      y_obs_d         = y_obs_q;
      prod_d          = prod_q;
      prod_idx_d      = prod_idx_q;
      mul_start_d     = 1'b0;
      resp_mismatch_d = resp_mismatch_q;
      resp_expected_d = resp_expected_q;
      txn_d           = txn_q;
      err_d           = err_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d         = a;
               b_d         = b;
               c_d         = c;
               d_d         = d;
               e_d         = e;
               mode_d      = mode;
               y_obs_d     = y_obs;
               prod_idx_d  = P1;
               mul_start_d = 1'b1;
               state_d     = MUL;
            end
         end
         MUL: begin
            // Every product is computed regardless of mode so latency never depends on it.
            if (mul_done) begin
               for (int i = 0; i < 4; i++) begin
                  if (prod_idx_q == 2'(i)) prod_d[i] = mul_product;
               end
               if (prod_idx_q == P4) begin
                  state_d = CMP;
               end else begin
                  prod_idx_d  = prod_idx_q + 2'd1;
                  mul_start_d = 1'b1;
               end
            end
         end
         CMP: begin
            resp_expected_d = expected_calc;
            resp_mismatch_d = (expected_calc != y_obs_q);
            state_d         = RESP;
         end
         default: begin
            if (resp_ready) begin
               if (txn_q != CNT_MAX) txn_d = txn_q + CNT_W'(1);
               if (resp_mismatch_q && (err_q != CNT_MAX)) err_d = err_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         a_q             <= 8'h00;
         b_q             <= 8'h00;
         c_q             <= 8'h00;
         d_q             <= 8'h00;
         e_q             <= 8'h00;
         mode_q          <= 2'd0;
         y_obs_q         <= 16'h0000;
         prod_q          <= '0;
         prod_idx_q      <= P1;
         mul_start_q     <= 1'b0;
         resp_mismatch_q <= 1'b0;
         resp_expected_q <= 16'h0000;
         txn_q           <= '0;
         err_q           <= '0;
      end else begin
         state_q         <= state_d;
         a_q             <= a_d;
         b_q             <= b_d;
         c_q             <= c_d;
         d_q             <= d_d;
         e_q             <= e_d;
         mode_q          <= mode_d;
         y_obs_q         <= y_obs_d;
         prod_q          <= prod_d;
         prod_idx_q      <= prod_idx_d;
         mul_start_q     <= mul_start_d;
         resp_mismatch_q <= resp_mismatch_d;
         resp_expected_q <= resp_expected_d;
         txn_q           <= txn_d;
         err_q           <= err_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign resp_valid    = (state_q == RESP);
   assign resp_mismatch = resp_mismatch_q;
   assign resp_expected = resp_expected_q;
   assign txn_count     = txn_q;
   assign err_count     = err_q;

endmodule

// File: tb/tb_trojan9_result_checker.sv
// Directed self-checking bench for trojan9_result_checker; a second instance with 4-bit
// counters shares the stimulus so counter saturation can be reached quickly.
module tb_trojan9_result_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  a = 8'h00, b = 8'h00, c = 8'h00, d = 8'h00, e = 8'h00;
   logic [1:0]  mode = 2'd0;
   logic [15:0] y_obs = 16'h0000;
   logic        resp_ready = 1'b0;

   logic        in_ready, resp_valid, resp_mismatch;
   logic [15:0] resp_expected, txn_count, err_count;
   logic        in_ready4, resp_valid4, resp_mismatch4;
   logic [15:0] resp_expected4;
   logic [3:0]  txn_count4, err_count4;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_txn  = 0;
   int exp_err  = 0;

   always #5 clk = ~clk;

   trojan9_result_checker dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .d(d), .e(e), .mode(mode), .y_obs(y_obs),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_mismatch(resp_mismatch),
      .resp_expected(resp_expected), .txn_count(txn_count), .err_count(err_count)
   );

   trojan9_result_checker #(.COMPUTATION_BIAS(16'h1234), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .a(a), .b(b), .c(c), .d(d), .e(e), .mode(mode), .y_obs(y_obs),
      .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_mismatch(resp_mismatch4),
      .resp_expected(resp_expected4), .txn_count(txn_count4), .err_count(err_count4)
   );

   // Present a tuple for one edge, then scramble the inputs to prove they are not re-sampled.
   task automatic do_accept(input logic [7:0] ta, tb_, tc, td, te,
                            input logic [1:0] tm, input logic [15:0] ty);
      @(negedge clk);
      a = ta; b = tb_; c = tc; d = td; e = te; mode = tm; y_obs = ty;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'h5A; b = 8'hA5; c = 8'h3C; d = 8'hC3; e = 8'h0F; mode = ~tm; y_obs = ~ty;
   endtask

   // lat counts negedges after the accept edge; lat == 38 means resp_valid in cycle T+38.
   task automatic wait_resp(output int lat);
      lat = 0;
      while (!resp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic handshake();
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      $display("txn: expected=%h mismatch=%b", resp_expected, resp_mismatch);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_txn = 0;
      exp_err = 0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (in_ready !== 1'b1 || resp_valid !== 1'b0) begin
         $display("FAIL reset_handshake: in_ready=%b resp_valid=%b, want 1/0", in_ready, resp_valid);
         n_fail++;
      end
      n_checks++;
      if (resp_mismatch !== 1'b0 || resp_expected !== 16'h0000) begin
         $display("FAIL reset_resp: mismatch=%b expected=%h, want 0/0000", resp_mismatch, resp_expected);
         n_fail++;
      end
      n_checks++;
      if (txn_count !== 16'd0 || err_count !== 16'd0 || txn_count4 !== 4'd0 || err_count4 !== 4'd0) begin
         $display("FAIL reset_counters: txn=%0d err=%0d txn4=%0d err4=%0d, want all 0",
                  txn_count, err_count, txn_count4, err_count4);
         n_fail++;
      end
   endtask

   task automatic test_basic();
      int lat;
      do_accept(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 2'd0, 16'h1249);
      n_checks++;
      if (in_ready !== 1'b0) begin
         $display("FAIL basic_busy: in_ready=%b, want 0", in_ready);
         n_fail++;
      end
      wait_resp(lat);
      n_checks++;
      if (lat != 38) begin
         $display("FAIL basic_latency: resp_valid at T+%0d, want T+38", lat);
         n_fail++;
      end
      n_checks++;
      if (resp_expected !== 16'h1249 || resp_mismatch !== 1'b0) begin
         $display("FAIL basic_result: expected=%h mismatch=%b, want 1249/0", resp_expected, resp_mismatch);
         n_fail++;
      end
      handshake();
      exp_txn++;
      @(negedge clk);
      n_checks++;
      if (txn_count !== 16'(exp_txn) || err_count !== 16'(exp_err) || in_ready !== 1'b1 || resp_valid !== 1'b0) begin
         $display("FAIL basic_counters: txn=%0d err=%0d in_ready=%b resp_valid=%b, want %0d/%0d/1/0",
                  txn_count, err_count, in_ready, resp_valid, exp_txn, exp_err);
         n_fail++;
      end
   endtask

   task automatic test_modes();
      logic [15:0] want [3];
      int lat;
      want[0] = 16'h123F;
      want[1] = 16'h1257;
      want[2] = 16'h125C;
      for (int i = 0; i < 3; i++) begin
         do_accept(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 2'(i + 1), 16'h0000);
         wait_resp(lat);
         n_checks++;
         if (lat != 38 || resp_expected !== want[i] || resp_mismatch !== 1'b1) begin
            $display("FAIL mode%0d: lat=%0d expected=%h mismatch=%b, want 38/%h/1",
                     i + 1, lat, resp_expected, resp_mismatch, want[i]);
            n_fail++;
         end
         handshake();
         exp_txn++;
         exp_err++;
      end
      @(negedge clk);
      n_checks++;
      if (txn_count !== 16'(exp_txn) || err_count !== 16'd3) begin
         $display("FAIL modes_counters: txn=%0d err=%0d, want %0d/3", txn_count, err_count, exp_txn);
         n_fail++;
      end
   endtask

   task automatic test_wrap();
      int lat;
      do_accept(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 2'd0, 16'h0A38);
      wait_resp(lat);
      n_checks++;
      if (lat != 38 || resp_expected !== 16'h0A38 || resp_mismatch !== 1'b0) begin
         $display("FAIL wrap_m1: lat=%0d expected=%h mismatch=%b, want 38/0a38/0", lat, resp_expected, resp_mismatch);
         n_fail++;
      end
      handshake();
      exp_txn++;
      do_accept(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 2'd3, 16'h063A);
      wait_resp(lat);
      n_checks++;
      if (lat != 38 || resp_expected !== 16'h063A || resp_mismatch !== 1'b0) begin
         $display("FAIL wrap_m4: lat=%0d expected=%h mismatch=%b, want 38/063a/0", lat, resp_expected, resp_mismatch);
         n_fail++;
      end
      handshake();
      exp_txn++;
   endtask

   task automatic test_back_to_back();
      int lat;
      int bad;
      do_accept(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 2'd0, 16'h1249);
      wait_resp(lat);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (resp_valid !== 1'b1 || in_ready !== 1'b0 || resp_expected !== 16'h1249 ||
             resp_mismatch !== 1'b0 || txn_count !== 16'(exp_txn))
            bad++;
         in_valid = (i >= 3 && i <= 5);
         a = 8'h10; b = 8'h20; c = 8'h30; d = 8'h40; e = 8'h07; mode = 2'd2; y_obs = 16'hBEEF;
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_checks++;
      if (bad != 0 || lat != 38) begin
         $display("FAIL backpressure_hold: %0d unstable cycles, lat=%0d, want 0 and 38", bad, lat);
         n_fail++;
      end
      handshake();
      exp_txn++;
      @(negedge clk);
      n_checks++;
      if (txn_count !== 16'(exp_txn) || err_count !== 16'(exp_err)) begin
         $display("FAIL backpressure_count: txn=%0d err=%0d, want %0d/%0d", txn_count, err_count, exp_txn, exp_err);
         n_fail++;
      end
      bad = 0;
      for (int i = 0; i < 45; i++) begin
         if (resp_valid !== 1'b0 || in_ready !== 1'b1) bad++;
         @(negedge clk);
      end
      n_checks++;
      if (bad != 0) begin
         $display("FAIL ignored_tuple: %0d cycles busy or responding, want 0", bad);
         n_fail++;
      end
   endtask

   task automatic test_abort();
      int lat;
      do_accept(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 2'd1, 16'h0000);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_txn = 0;
      exp_err = 0;
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0 || in_ready !== 1'b1 || txn_count !== 16'd0 || err_count !== 16'd0 ||
          resp_expected !== 16'h0000) begin
         $display("FAIL abort_state: resp_valid=%b in_ready=%b txn=%0d err=%0d expected=%h, want 0/1/0/0/0000",
                  resp_valid, in_ready, txn_count, err_count, resp_expected);
         n_fail++;
      end
      do_accept(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 2'd1, 16'h0000);
      wait_resp(lat);
      n_checks++;
      if (lat != 38 || resp_expected !== 16'h123F || resp_mismatch !== 1'b1) begin
         $display("FAIL abort_fresh: lat=%0d expected=%h mismatch=%b, want 38/123f/1", lat, resp_expected, resp_mismatch);
         n_fail++;
      end
      handshake();
      exp_txn++;
      exp_err++;
      @(negedge clk);
      n_checks++;
      if (txn_count !== 16'(exp_txn) || err_count !== 16'(exp_err)) begin
         $display("FAIL abort_count: txn=%0d err=%0d, want %0d/%0d", txn_count, err_count, exp_txn, exp_err);
         n_fail++;
      end
   endtask

   task automatic test_saturation();
      int lat;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         do_accept(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 2'd0, 16'h0000);
         wait_resp(lat);
         handshake();
         exp_txn++;
         exp_err++;
         @(negedge clk);
         if (i == 15) begin
            n_checks++;
            if (err_count4 !== 4'hF || err_count !== 16'd16) begin
               $display("FAIL sat_reach: err4=%h err=%0d, want f/16", err_count4, err_count);
               n_fail++;
            end
         end
      end
      n_checks++;
      if (err_count4 !== 4'hF || txn_count4 !== 4'hF) begin
         $display("FAIL sat_hold: err4=%h txn4=%h, want f/f", err_count4, txn_count4);
         n_fail++;
      end
      n_checks++;
      if (err_count !== 16'(exp_err) || txn_count !== 16'(exp_txn)) begin
         $display("FAIL sat_wide: err=%0d txn=%0d, want %0d/%0d", err_count, txn_count, exp_err, exp_txn);
         n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_modes();
      test_wrap();
      test_back_to_back();
      test_abort();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
